// File: rtl/rv_uart_capture_if.sv
// Received-byte stream between the UART capture block and its consumer.
// The master drives the byte and valid, the slave answers with ready.
interface rv_uart_capture_if;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready;

    modport master (
        output m_valid,
        output m_data,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        output m_ready
    );
endinterface

// File: rtl/rv_uart_capture.sv
// UART capture for SoC test harnesses: an 8N1 receiver feeding a small FIFO,
// sticky frame-error / overflow flags and a cycle counter that freezes on the
// first ebreak from the SoC.
module rv_uart_capture #(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      uart_rx,
    input  logic                      ebreak,
    rv_uart_capture_if.master         m,
    output logic                      frame_err,
    output logic                      overflow,
    output logic [31:0]               cycles,
    output logic                      done
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;
    localparam int PTR_W        = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   COUNT_ZERO = (PTR_W + 1)'(0);

    // Oversampling needs at least a few clocks per bit to find the middle.
    if (CLKS_PER_BIT < 4) begin : g_bad_baud
        $error("rv_uart_capture: CLOCK_FREQ/BAUD_RATE must be at least 4");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("rv_uart_capture: FIFO_DEPTH must be a power of 2, at least 2");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        RECOVER = 3'd4
    } rx_state_t;

    // ------------------------------------------------------------------
    // Line synchronizer
    // ------------------------------------------------------------------
    logic sync1_r;
    logic sync2_r;

    // Two-flop synchronizer; reset to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= uart_rx;
            sync2_r <= sync1_r;
        end
    end

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    rx_state_t        state_r, state_n;
    logic [CNT_W-1:0] cnt_r, cnt_n;
    logic [2:0]       bit_r, bit_n;
    logic [7:0]       shift_r, shift_n;
    logic             push_r, push_n;
    logic             ferr_set_s;

    // Receiver state and datapath registers; push is delayed one cycle
    // after the stop-bit sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            bit_r   <= 3'd0;
            shift_r <= 8'h00;
            push_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            bit_r   <= bit_n;
            shift_r <= shift_n;
            push_r  <= push_n;
        end
    end

    // Next-state logic: half-bit wait for the start bit, then one sample per
    // bit period centred in each bit.
    always_comb begin
        state_n    = state_r;
        cnt_n      = cnt_r;
        bit_n      = bit_r;
        shift_n    = shift_r;
        push_n     = 1'b0;
        ferr_set_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (!sync2_r) begin
                    state_n = START;
                    cnt_n   = CNT_ZERO;
                    bit_n   = 3'd0;
                end else begin
                    state_n = IDLE;
                end
            end
            START: begin
                if (cnt_r == HALF_LAST) begin
                    cnt_n = CNT_ZERO;
                    if (!sync2_r) begin
                        state_n = DATA;
                    end else begin
                        state_n = IDLE;   // glitch, not a real start bit
                    end
                end else begin
                    cnt_n = cnt_r + CNT_ONE;
                end
            end
            DATA: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_n   = CNT_ZERO;
                    shift_n = {sync2_r, shift_r[7:1]};   // LSB arrives first
                    bit_n   = bit_r + 3'd1;
                    if (bit_r == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        state_n = DATA;
                    end
                end else begin
                    cnt_n = cnt_r + CNT_ONE;
                end
            end
            STOP: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_n = CNT_ZERO;
                    if (sync2_r) begin
                        push_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr_set_s = 1'b1;
                        state_n    = RECOVER;
                    end
                end else begin
                    cnt_n = cnt_r + CNT_ONE;
                end
            end
            RECOVER: begin
                if (sync2_r) begin
                    state_n = IDLE;
                end else begin
                    state_n = RECOVER;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic [7:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r, rd_next_s;
    logic [PTR_W:0]   count_r, count_n;
    logic             m_valid_r;
    logic [7:0]       m_data_r, head_n, m_data_n;
    logic             overflow_r, frame_err_r;
    logic             full_s, pop_s, do_push_s, drop_s;

    // FIFO control: a full FIFO still accepts a push when it is popped in
    // the same cycle; the output byte register tracks the next head.
    always_comb begin
        full_s    = (count_r == FULL_COUNT);
        pop_s     = m_valid_r && m.m_ready;
        do_push_s = push_r && (!full_s || pop_s);
        drop_s    = push_r && full_s && !pop_s;
        rd_next_s = rd_ptr_r + PTR_W'(pop_s);
        case ({do_push_s, pop_s})
            2'b10:   count_n = count_r + COUNT_ONE;
            2'b01:   count_n = count_r - COUNT_ONE;
            default: count_n = count_r;
        endcase
        if (do_push_s && (wr_ptr_r == rd_next_s)) begin
            head_n = shift_r;
        end else begin
            head_n = mem_r[rd_next_s];
        end
        if (count_n == COUNT_ZERO) begin
            m_data_n = m_data_r;
        end else begin
            m_data_n = head_n;
        end
    end

    // FIFO storage; contents need no reset since occupancy governs validity.
    always_ff @(posedge clk) begin
        if (!rst && do_push_s) begin
            mem_r[wr_ptr_r] <= shift_r;
        end
    end

    // FIFO pointers, occupancy, registered stream outputs and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= COUNT_ZERO;
            m_valid_r   <= 1'b0;
            m_data_r    <= 8'h00;
            overflow_r  <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            rd_ptr_r  <= rd_next_s;
            count_r   <= count_n;
            m_valid_r <= (count_n != COUNT_ZERO);
            m_data_r  <= m_data_n;
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
            if (ferr_set_s) begin
                frame_err_r <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Run-time counter
    // ------------------------------------------------------------------
    logic [31:0] cycles_r;
    logic        done_r;

    // Count cycles until the first ebreak; that cycle still counts, then
    // the value freezes. Saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycles_r <= 32'd0;
            done_r   <= 1'b0;
        end else if (!done_r) begin
            if (cycles_r != 32'hFFFF_FFFF) begin
                cycles_r <= cycles_r + 32'd1;
            end
            if (ebreak) begin
                done_r <= 1'b1;
            end
        end
    end

    assign m.m_valid = m_valid_r;
    assign m.m_data  = m_data_r;
    assign frame_err = frame_err_r;
    assign overflow  = overflow_r;
    assign cycles    = cycles_r;
    assign done      = done_r;

endmodule

// File: tb/tb_rv_uart_capture.sv
// Self-checking bench for rv_uart_capture (16 clocks per bit, 4-entry FIFO).
module tb_rv_uart_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic        uart_rx;
    logic        ebreak;
    logic        frame_err;
    logic        overflow;
    logic        done;
    logic [31:0] cycles;

    int checks   = 0;
    int failures = 0;

    typedef logic [7:0] bq_t[$];
    bq_t  rcv_q;
    int   valid_hi;
    logic rand_ready;
    logic hold_prev;
    logic [7:0] data_prev;

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic       exp_push;
        logic       exp_ferr;
    } vec_t;
    vec_t vecs[6];

    rv_uart_capture_if ifc();

    rv_uart_capture #(
        .CLOCK_FREQ(16),
        .BAUD_RATE (1),
        .FIFO_DEPTH(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .uart_rx  (uart_rx),
        .ebreak   (ebreak),
        .m        (ifc),
        .frame_err(frame_err),
        .overflow (overflow),
        .cycles   (cycles),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic check_rcv(input string name, input bq_t exp);
        check({name, "_count"}, 32'(rcv_q.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < rcv_q.size(); i++) begin
            check({name, "_byte"}, 32'(rcv_q[i]), 32'(exp[i]));
        end
    endtask

    // Consumer-side monitor: collects accepted bytes and checks hold stability.
    always @(negedge clk) begin
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", 32'(ifc.m_valid), 32'd1);
                check("hold_data", 32'(ifc.m_data), 32'(data_prev));
            end
            if (ifc.m_valid) valid_hi++;
            if (ifc.m_valid && ifc.m_ready) rcv_q.push_back(ifc.m_data);
            hold_prev = ifc.m_valid && !ifc.m_ready;
            data_prev = ifc.m_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) ifc.m_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int gap);
        uart_rx = 1'b0;
        repeat (16) tick();
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            repeat (16) tick();
        end
        uart_rx = stop_bit;
        repeat (16) tick();
        uart_rx = 1'b1;
        repeat (gap) tick();
    endtask

    task automatic do_reset();
        uart_rx = 1'b1;
        ebreak  = 1'b0;
        rst     = 1'b1;
        tick();
        rst     = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_m_valid"},   32'(ifc.m_valid), 32'd0);
        check({tag, "_m_data"},    32'(ifc.m_data),  32'd0);
        check({tag, "_frame_err"}, 32'(frame_err),   32'd0);
        check({tag, "_overflow"},  32'(overflow),    32'd0);
        check({tag, "_cycles"},    cycles,           32'd0);
        check({tag, "_done"},      32'(done),        32'd0);
    endtask

    initial begin
        bq_t        exp_q;
        logic [7:0] d;
        logic       stop_ok;
        logic       any_bad;

        vecs[0] = '{8'h00, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'hFF, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'h80, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'h01, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{8'hA5, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{8'h5A, 1'b1, 1'b1, 1'b1};

        rst         = 1'b1;
        uart_rx     = 1'b1;
        ebreak      = 1'b0;
        ifc.m_ready = 1'b0;
        rand_ready  = 1'b0;
        valid_hi    = 0;

        do_reset();
        check_reset_state("reset");

        // Single byte with a ready consumer: one-cycle valid pulse.
        ifc.m_ready = 1'b1;
        rcv_q.delete();
        valid_hi = 0;
        send_frame(8'h55, 1'b1, 20);
        check_rcv("single_55", '{8'h55});
        check("single_valid_cycles", 32'(valid_hi), 32'd1);
        check("single_frame_err", 32'(frame_err), 32'd0);

        // Three bytes queued behind a stalled consumer.
        ifc.m_ready = 1'b0;
        rcv_q.delete();
        exp_q = '{8'h41, 8'h42, 8'h43};
        foreach (exp_q[k]) begin
            send_frame(exp_q[k], 1'b1, 20);
            check("stall_valid", 32'(ifc.m_valid), 32'd1);
            check("stall_head", 32'(ifc.m_data), 32'h41);
        end
        ifc.m_ready = 1'b1;
        repeat (10) tick();
        check_rcv("stall_drain", exp_q);
        check("stall_empty_valid", 32'(ifc.m_valid), 32'd0);

        // Table of single frames; frame_err is sticky across entries.
        for (int i = 0; i < 6; i++) begin
            rcv_q.delete();
            exp_q = {};
            if (vecs[i].exp_push) exp_q.push_back(vecs[i].data);
            send_frame(vecs[i].data, vecs[i].stop_bit, 20);
            check_rcv("table_rx", exp_q);
            check("table_frame_err", 32'(frame_err), 32'(vecs[i].exp_ferr));
        end

        // Overflow: fifth byte dropped, first four kept.
        do_reset();
        ifc.m_ready = 1'b0;
        rcv_q.delete();
        for (int k = 1; k <= 5; k++) begin
            send_frame(8'(k), 1'b1, 20);
            check("ovf_flag", 32'(overflow), (k == 5) ? 32'd1 : 32'd0);
        end
        ifc.m_ready = 1'b1;
        repeat (10) tick();
        check_rcv("ovf_drain", '{8'h01, 8'h02, 8'h03, 8'h04});
        check("ovf_empty_valid", 32'(ifc.m_valid), 32'd0);

        // Framing error, then recovery with a good byte.
        do_reset();
        ifc.m_ready = 1'b1;
        rcv_q.delete();
        send_frame(8'hA5, 1'b0, 20);
        check("ferr_set", 32'(frame_err), 32'd1);
        check("ferr_no_push", 32'(rcv_q.size()), 32'd0);
        send_frame(8'h3C, 1'b1, 20);
        check_rcv("ferr_recover", '{8'h3C});
        check("ferr_sticky", 32'(frame_err), 32'd1);

        // Short glitch right after reset, then ebreak in the 1000th cycle.
        do_reset();
        rcv_q.delete();
        for (int i = 0; i < 999; i++) begin
            uart_rx = (i < 4) ? 1'b0 : 1'b1;
            tick();
        end
        ebreak = 1'b1;
        tick();
        ebreak = 1'b0;
        check("ebreak_done", 32'(done), 32'd1);
        check("ebreak_cycles", cycles, 32'd1000);
        check("glitch_no_byte", 32'(rcv_q.size()), 32'd0);
        check("glitch_no_ferr", 32'(frame_err), 32'd0);
        for (int i = 0; i < 30; i++) begin
            ebreak = 1'($urandom_range(0, 1));
            tick();
        end
        ebreak = 1'b0;
        send_frame(8'hC3, 1'b1, 20);
        check_rcv("after_done_rx", '{8'hC3});
        check("after_done_cycles", cycles, 32'd1000);
        check("after_done_flag", 32'(done), 32'd1);

        // Reset in the middle of the data bits of 0x7E.
        do_reset();
        ifc.m_ready = 1'b1;
        rcv_q.delete();
        d = 8'h7E;
        uart_rx = 1'b0;
        repeat (16) tick();
        for (int i = 0; i < 3; i++) begin
            uart_rx = d[i];
            repeat (16) tick();
        end
        uart_rx = d[3];
        repeat (8) tick();
        do_reset();
        check_reset_state("midreset");
        repeat (20) tick();
        send_frame(8'h12, 1'b1, 20);
        check_rcv("midreset_next", '{8'h12});
        check("midreset_ferr", 32'(frame_err), 32'd0);

        // Randomized frames, random consumer stalls, occasional bad stop bits.
        do_reset();
        rcv_q.delete();
        exp_q = {};
        any_bad = 1'b0;
        rand_ready = 1'b1;
        for (int n = 0; n < 24; n++) begin
            d       = 8'($urandom());
            stop_ok = ($urandom_range(0, 3) != 0);
            send_frame(d, stop_ok, int'($urandom_range(4, 40)));
            if (stop_ok) exp_q.push_back(d);
            else any_bad = 1'b1;
        end
        rand_ready  = 1'b0;
        ifc.m_ready = 1'b1;
        repeat (10) tick();
        check_rcv("rand_rx", exp_q);
        check("rand_frame_err", 32'(frame_err), 32'(any_bad));
        check("rand_overflow", 32'(overflow), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv_uart_capture.md
RV_UART_CAPTURE -- requirements
Module: rv_uart_capture

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 100_000_000, system clock in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, serial bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, received-byte buffer entries, power of 2, at least 2.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port uart_rx  input  1  serial line from SoC uart_tx; idles high; asynchronous to clk.
REQ-007 SHALL have port ebreak  input  1  SoC halt indication.
REQ-008 SHALL have port m_valid  output  1  received byte available.
REQ-009 SHALL have port m_data  output  8  oldest received byte.
REQ-010 SHALL have port m_ready  input  1  consumer accepts byte.
REQ-011 SHALL have port frame_err  output  1  sticky: stop bit sampled low.
REQ-012 SHALL have port overflow  output  1  sticky: byte dropped because FIFO full.
REQ-013 SHALL have port cycles  output  32  clock cycles from reset release to first ebreak.
REQ-014 SHALL have port done  output  1  sticky: ebreak seen.

Function
REQ-015 SHALL use CLKS_PER_BIT = CLOCK_FREQ/BAUD_RATE (integer division); elaboration SHALL fail if CLKS_PER_BIT < 4.
REQ-016 SHALL pass uart_rx through a 2-flop synchronizer (both flops reset to 1); the receiver SHALL act only on the synchronized value.
REQ-017 SHALL implement receiver states IDLE, START, DATA, STOP, RECOVER.
REQ-018 IDLE: synchronized line low -> START, bit counter cleared.
REQ-019 START: after CLKS_PER_BIT/2 cycles, sample; low -> DATA; high (glitch) -> IDLE, nothing pushed, no error.
REQ-020 DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first; after the 8th bit -> STOP.
REQ-021 STOP: sample after CLKS_PER_BIT cycles; high -> push byte, go to IDLE; low -> discard byte, set frame_err, go to RECOVER.
REQ-022 RECOVER: stay until synchronized line high, then IDLE.
REQ-023 Push SHALL occur in the cycle after the stop-bit sample; m_valid SHALL rise the cycle after the push when the FIFO was empty.
REQ-024 FIFO SHALL be first-in first-out; pop occurs when m_valid && m_ready.
REQ-025 m_valid SHALL be high exactly when the FIFO is non-empty.
REQ-026 m_data SHALL be stable while m_valid && !m_ready.
REQ-027 Push while full without pop in the same cycle: byte dropped, contents unchanged, overflow set.
REQ-028 Push and pop in the same cycle while full: both accepted, occupancy unchanged, no overflow.
REQ-029 Push and pop in the same cycle while empty is impossible (m_valid low), so the push SHALL only fill.
REQ-030 Pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be distinguished by an extra pointer bit or an occupancy count.
REQ-031 cycles SHALL increment by 1 each cycle after reset while done is low.
REQ-032 cycles SHALL saturate at 0xFFFF_FFFF.
REQ-033 First cycle with ebreak high: done set and cycles frozen, including that cycle's increment; later ebreak values SHALL be ignored.
REQ-034 The receiver SHALL keep operating after done.

Reset
REQ-035 On rst high at a clock edge: state IDLE, FIFO empty, m_valid 0, m_data 0, frame_err 0, overflow 0, cycles 0, done 0, synchronizer flops 1.
REQ-036 Reset mid-frame SHALL abandon the partial byte with no push and no error flag.
REQ-037 A start edge during the first cycle after reset SHALL be seen only through the synchronizer, i.e. at least 2 cycles later.

Verification (CLOCK_FREQ=16, BAUD_RATE=1 -> CLKS_PER_BIT=16, FIFO_DEPTH=4)
REQ-038 Send 0x55 with a correct frame and m_ready=1 -> m_valid pulses for one cycle with m_data=0x55; frame_err=0.
REQ-039 Send 0x41, 0x42, 0x43 with m_ready=0 -> m_valid stays high with m_data=0x41 stable; then raise m_ready -> 0x41, 0x42, 0x43 delivered in order, then m_valid=0.
REQ-040 Send 5 bytes 0x01..0x05 with m_ready=0 -> overflow=1, FIFO holds 0x01..0x04; raise m_ready -> exactly those 4 bytes.
REQ-041 Send 0xA5 with stop bit low -> no push, frame_err=1, receiver back in IDLE after the line returns high; next byte 0x3C received correctly.
REQ-042 Drive uart_rx low for 4 cycles only -> no byte, no frame_err; ebreak asserted 1000 cycles after reset release -> done=1, cycles=1000 and constant thereafter.
REQ-043 Assert rst in the middle of DATA of byte 0x7E -> all outputs at reset values; next full byte 0x12 received correctly.
